// File: rtl/cnu_min_sched_pkg.sv
// Shared constants for the serial check-node min-finder: message width,
// index width and the two supported check-node degrees.
package cnu_min_sched_pkg;

  localparam int QUAN_SIZE = 4;
  localparam int IDX_W_DEF = 3;
  localparam int CN_DEGREE = 8;
  localparam int DEG_LO    = 6;
  localparam int DEG_HI    = 8;

  function automatic int unsigned deg_of(input logic deg8);
    return deg8 ? DEG_HI : DEG_LO;
  endfunction

endpackage

// File: rtl/cnu_min_update.sv
// One compare/update step of the two-minimum tracker. Strict compares keep
// the earliest index on ties while still letting an equal value become m2.
module cnu_min_update #(
  parameter int QW = 4,
  parameter int IW = 3
) (
  input  logic [QW-1:0] m1,
  input  logic [QW-1:0] m2,
  input  logic [IW-1:0] idx,
  input  logic [QW-1:0] x,
  input  logic [IW-1:0] k,
  output logic [QW-1:0] m1_nx,
  output logic [QW-1:0] m2_nx,
  output logic [IW-1:0] idx_nx
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    m1_nx  = m1;
    m2_nx  = m2;
    idx_nx = idx;
    if (x < m1) begin
      m2_nx  = m1;
      m1_nx  = x;
      idx_nx = k;
    end else if (x < m2) begin
      m2_nx = x;
    end
  end

endmodule

// File: rtl/cnu_min_sched.sv
// Serial check-node unit: accumulates a 6- or 8-message pattern one beat per
// handshake and presents the two smallest magnitudes plus the index of the smallest.
module cnu_min_sched
  import cnu_min_sched_pkg::*;
#(
  parameter int QUAN_SIZE = cnu_min_sched_pkg::QUAN_SIZE,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 deg_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUAN_SIZE-1:0] m1,
  output logic [QUAN_SIZE-1:0] m2,
  output logic [IDX_W-1:0]     min_index,
  output logic                 busy
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic                   deg8_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          d_cnt;
  logic                   accept;
  logic [QUAN_SIZE-1:0]   u_m1, u_m2, m1_nx, m2_nx;
  logic [IDX_W-1:0]       u_idx, u_k, idx_nx;

  assign in_ready = (state != DONE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign d_cnt    = CW'(deg_of(deg8_q));

  // The first beat is folded in by seeding the tracker with all-ones.
  assign u_m1  = (state == IDLE) ? '1 : m1;
  assign u_m2  = (state == IDLE) ? '1 : m2;
  assign u_idx = (state == IDLE) ? '0 : min_index;
  assign u_k   = (state == IDLE) ? '0 : cnt[IDX_W-1:0];

  cnu_min_update #(.QW(QUAN_SIZE), .IW(IDX_W)) u_update (
    .m1     (u_m1),
    .m2     (u_m2),
    .idx    (u_idx),
    .x      (in_msg),
    .k      (u_k),
    .m1_nx  (m1_nx),
    .m2_nx  (m2_nx),
    .idx_nx (idx_nx)
  );

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      deg8_q    <= 1'b0;
      cnt       <= '0;
      m1        <= '0;
      m2        <= '0;
      min_index <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          deg8_q    <= deg_sel;
          m1        <= m1_nx;
          m2        <= m2_nx;
          min_index <= idx_nx;
          cnt       <= CW'(1);
          state     <= ACCUM;
        end
        ACCUM: if (accept) begin
          m1        <= m1_nx;
          m2        <= m2_nx;
          min_index <= idx_nx;
          cnt       <= cnt + CW'(1);
          if (cnt + CW'(1) == d_cnt) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_min_sched.sv
// Randomized and directed bench for cnu_min_sched against a sort-based
// reference of the two smallest messages and the earliest index of the minimum.
module tb_cnu_min_sched;

  localparam int QW = 4;
  localparam int IW = 3;

  logic          sys_clk   = 1'b0;
  logic          rstn      = 1'b0;
  logic          deg_sel   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [QW-1:0] in_msg    = '0;
  logic          in_ready, out_valid, busy;
  logic [QW-1:0] m1, m2;
  logic [IW-1:0] min_index;

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [QW-1:0] msg_arr_t [8];

  cnu_min_sched #(.QUAN_SIZE(QW), .IDX_W(IW)) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .deg_sel   (deg_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m1        (m1),
    .m2        (m2),
    .min_index (min_index),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sorted multiset: m1 and m2 are its first two entries.
  function automatic void ref_min(input msg_arr_t v, input int n,
                                  output int r1, output int r2, output int ri);
    int q[$];
    for (int i = 0; i < n; i++) q.push_back(int'(v[i]));
    q.sort();
    r1 = q[0];
    r2 = q[1];
    ri = 0;
    for (int i = n - 1; i >= 0; i--) if (int'(v[i]) == r1) ri = i;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // gaps: bit i set inserts one idle cycle before beat i.
  // stall: cycles out_valid is shown with out_ready low before the handshake.
  task automatic run_pattern(input string name, input bit dsel, input msg_arr_t v,
                             input int gaps, input int stall, input bit flip);
    int n;
    int r1, r2, ri;
    n = dsel ? 8 : 6;
    ref_min(v, n, r1, r2, ri);
    out_ready = (stall == 0);
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        in_valid = 1'b0;
        in_msg   = 4'($urandom);
        deg_sel  = 1'($urandom);
        tick();
        if (i > 0) check({name, " gap out_valid"}, out_valid, 0);
      end
      in_valid = 1'b1;
      in_msg   = v[i];
      deg_sel  = (i == 0) ? dsel : (flip ? ~dsel : 1'($urandom));
      check({name, " in_ready"}, in_ready, 1);
      if (i == n - 1) check({name, " early out_valid"}, out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    in_msg   = 4'($urandom);
    deg_sel  = 1'($urandom);
    check({name, " latency out_valid"}, out_valid, 1);
    check({name, " m1"}, m1, r1);
    check({name, " m2"}, m2, r2);
    check({name, " min_index"}, min_index, ri);
    check({name, " done in_ready"}, in_ready, 0);
    check({name, " done busy"}, busy, 1);
    for (int s = 0; s < stall - 1; s++) begin
      tick();
      check({name, " stall out_valid"}, out_valid, 1);
      check({name, " stall in_ready"}, in_ready, 0);
      check({name, " stall m1"}, m1, r1);
      check({name, " stall m2"}, m2, r2);
      check({name, " stall min_index"}, min_index, ri);
    end
    out_ready = 1'b1;
    tick();
    check({name, " post out_valid"}, out_valid, 0);
    check({name, " post busy"}, busy, 0);
    check({name, " post in_ready"}, in_ready, 1);
  endtask

  initial begin
    msg_arr_t v;
    rstn = 1'b0;
    repeat (2) tick();
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset m1", m1, 0);
    check("reset m2", m2, 0);
    check("reset min_index", min_index, 0);
    rstn = 1'b1;
    check("reset in_ready", in_ready, 1);

    v = '{4'd9, 4'd3, 4'd7, 4'd3, 4'd12, 4'd1, 4'd5, 4'd2};
    run_pattern("d8_basic", 1'b1, v, 0, 0, 1'b0);
    v = '{4'd4, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd0};
    run_pattern("d6_tie", 1'b0, v, 0, 0, 1'b0);
    v = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0};
    run_pattern("d6_stall", 1'b0, v, 0, 5, 1'b0);
    v = '{4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_pattern("d8_gaps", 1'b1, v, (1 << 2) | (1 << 6), 0, 1'b0);

    // Abort a D=8 pattern after 4 beats with an asynchronous reset.
    v = '{4'd9, 4'd3, 4'd7, 4'd3, 4'd12, 4'd1, 4'd5, 4'd2};
    deg_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_msg   = v[i];
      tick();
      deg_sel  = 1'b0;
    end
    in_valid = 1'b0;
    #3 rstn = 1'b0;
    #1;
    check("midrst m1", m1, 0);
    check("midrst m2", m2, 0);
    check("midrst min_index", min_index, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst busy", busy, 0);
    repeat (2) tick();
    rstn = 1'b1;
    check("midrst in_ready", in_ready, 1);
    v = '{4'd2, 4'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0};
    run_pattern("after_rst", 1'b0, v, 0, 0, 1'b0);

    v = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    run_pattern("flip_a", 1'b0, v, 0, 0, 1'b1);
    run_pattern("flip_b", 1'b1, v, 0, 0, 1'b1);

    for (int p = 0; p < 30; p++) begin
      int hi;
      hi = ($urandom_range(0, 1) != 0) ? 3 : 15;
      for (int i = 0; i < 8; i++) v[i] = 4'($urandom_range(0, hi));
      run_pattern($sformatf("rand%0d", p), 1'($urandom), v,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : 0,
                  int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cnu_min_sched.md
CNU_MIN_SCHED -- requirements
Module: cnu_min_sched

Interface
REQ-001 Parameter QUAN_SIZE, default `QUAN_SIZE (4), sets the message width in bits.
REQ-002 Parameter IDX_W, default 3, sets the width of the min-index field; it shall be large enough to hold 0..7.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 deg_sel  input  1  check-node degree select, 0 = degree 6, 1 = degree 8; sampled only on the first accepted beat of a pattern.
REQ-006 in_valid  input  1  in_msg carries a valid variable-to-check message.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_msg  input  QUAN_SIZE  message magnitude, treated as unsigned.
REQ-009 out_valid  output  1  m1, m2 and min_index hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 m1  output  QUAN_SIZE  smallest message of the pattern.
REQ-012 m2  output  QUAN_SIZE  second-smallest message of the pattern.
REQ-013 min_index  output  IDX_W  beat position (0-based) of m1.
REQ-014 busy  output  1  high while in ACCUM or DONE.

Function
REQ-015 The block shall serially accumulate one check-node pattern of D messages, one per handshake (in_valid && in_ready), where D = 6 or 8 as latched from deg_sel.
REQ-016 The FSM shall have three states: IDLE, ACCUM and DONE.
REQ-017 IDLE: in_ready=1; on an accepted beat, latch D, set m1=in_msg, m2=all-ones, min_index=0, beat count=1, and go to ACCUM.
REQ-018 ACCUM: in_ready=1; for each accepted beat at position k:
- if in_msg < m1: m2=m1, m1=in_msg, min_index=k;
- else if in_msg < m2: m2=in_msg;
- otherwise no change.
REQ-019 Ties shall keep the earlier index, since the comparisons are strict; a value equal to m1 shall update m2 to that value if it is below the current m2.
REQ-020 When the D-th beat is accepted, the FSM shall move to DONE; out_valid shall assert in the cycle after that beat is accepted (latency 1).
REQ-021 DONE: in_ready=0, out_valid=1, and m1, m2, min_index shall be held stable until out_ready=1.
REQ-022 On out_valid && out_ready, the FSM shall return to IDLE and deassert out_valid in the next cycle; the output values may be held.
REQ-023 Throughput shall be at most one pattern per D+1 cycles; in_ready shall not combinationally depend on out_ready.
REQ-024 Cycles with in_valid=0 in ACCUM shall leave all state unchanged (gaps allowed).
REQ-025 Changes to deg_sel during ACCUM or DONE shall have no effect.
REQ-026 The beat counter shall be IDX_W+1 bits wide and shall never wrap within a pattern.

Reset
REQ-027 Asserting rstn low at any time, including mid-pattern, shall immediately force state=IDLE, out_valid=0, busy=0, m1=0, m2=0, min_index=0, count=0 and latched D=6; a partial pattern is discarded.
REQ-028 After reset, in_ready shall be 1 in the first cycle after rstn deasserts.

Structure
REQ-029 QUAN_SIZE and CN_DEGREE shall come from the shared define.v; FSM state encodings shall be localparams in the module.
REQ-030 The compare/update step shall be a single combinational sub-module, cnu_min_update, with inputs (m1, m2, idx, x, k) and outputs (m1', m2', idx'), instantiated once.

Verification (QUAN_SIZE=4)
REQ-031 D=8, beats 9,3,7,3,12,1,5,2 back-to-back, out_ready=1 -> m1=1, m2=2, min_index=5; out_valid is 1 exactly one cycle after the last beat.
REQ-032 D=6, beats 4,4,8,9,10,11 -> m1=4, m2=4, min_index=0 (tie keeps earliest).
REQ-033 D=6, beats 15,15,15,15,15,15 with out_ready held 0 for 5 cycles -> m1=m2=15, min_index=0, outputs stable and in_ready=0 throughout the stall; then one handshake, and IDLE the next cycle.
REQ-034 D=8 with in_valid gaps (idle cycles between beats 2 and 3, and between beats 6 and 7), beats 5,6,7,0,1,2,3,4 -> m1=0, m2=1, min_index=3.
REQ-035 Assert rstn low after 4 beats of a D=8 pattern; then send a fresh D=6 pattern 2,1,3,3,3,3 -> all outputs 0 during reset, then m1=1, m2=2, min_index=1.
REQ-036 Two patterns back-to-back with deg_sel toggled mid-pattern -> each pattern uses its first-beat deg_sel; a bench comparison against combinational min-of-6/8 reference models matches for all patterns.
